// File: rtl/bbox_pkg.sv
// Shared types for the bounding-box filter: FSM state encoding and the packed box.
package bbox_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    COAST   = 2'd3
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] left;
    logic [X_W-1:0] right;
    logic [Y_W-1:0] top;
    logic [Y_W-1:0] bot;
  } box_t;

endpackage

// File: rtl/edge_ema.sv
// One box edge: next filtered value and jump check, purely combinational (0 cycles, no backpressure).
// BBOX_FILTER_EMA_EN selects the EMA step; without it the step is zero-shift, i.e. a direct load of raw.
module edge_ema #(
  parameter int W        = 11,
  parameter int SHIFT    = 2,
  parameter int JUMP_MAX = 64
) (
  input  logic [W-1:0] filt,
  input  logic [W-1:0] raw,
  output logic [W-1:0] nxt,
  output logic         near
);

`ifdef BBOX_FILTER_EMA_EN
  localparam bit EMA_ON = 1'b1;
`else
  localparam bit EMA_ON = 1'b0;
`endif
  localparam int DW = W + 1;
  localparam int SH = EMA_ON ? SHIFT : 0;
  localparam logic [DW-1:0] JUMP_C = DW'(JUMP_MAX);

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] step;
  logic signed [DW-1:0] sum;
  logic        [DW-1:0] mag;

  always_comb begin
    diff = signed'({1'b0, raw}) - signed'({1'b0, filt});
    mag  = diff[DW-1] ? $unsigned(-diff) : $unsigned(diff);
    near = (mag <= JUMP_C);
    // Small positive gaps would floor to zero; force a unit step so filt lands exactly on raw.
    step = diff >>> SH;
    if (step == '0 && diff != '0) begin
      step = {{(DW-1){1'b0}}, 1'b1};
    end
    sum = signed'({1'b0, filt}) + step;
    // The step never overshoots raw, so sum stays in range; the clamp only guards against wrap.
    nxt = sum[DW-1] ? '0 : sum[W-1:0];
  end

endmodule

// File: rtl/bbox_filter.sv
// Bounding-box tracker: sanity/jump gating, per-edge smoothing, SEARCH/ACQUIRE/TRACK/COAST lock FSM.
// Latency 1 cycle from valid_in to valid_out; no backpressure. Optional EMA via BBOX_FILTER_EMA_EN.
module bbox_filter
  import bbox_pkg::*;
#(
  parameter int WIDTH       = 480,
  parameter int HEIGHT      = 640,
  parameter int SHIFT       = 2,
  parameter int JUMP_MAX    = 64,
  parameter int LOCK_FRAMES = 3,
  parameter int LOST_FRAMES = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           valid_in,
  input  logic [X_W-1:0] left_in,
  input  logic [X_W-1:0] right_in,
  input  logic [Y_W-1:0] top_in,
  input  logic [Y_W-1:0] bot_in,
  input  logic           frame_in,
  output logic           valid_out,
  output logic [X_W-1:0] left_out,
  output logic [X_W-1:0] right_out,
  output logic [Y_W-1:0] top_out,
  output logic [Y_W-1:0] bot_out,
  output logic           locked_out,
  output logic [1:0]     state_out
);

  localparam int HW = $clog2(LOCK_FRAMES + 1);
  localparam int MW = $clog2(LOST_FRAMES + 1);
  localparam logic [HW-1:0]  LOCK_C   = HW'(LOCK_FRAMES);
  localparam logic [MW-1:0]  LOST_C   = MW'(LOST_FRAMES);
  localparam logic [X_W-1:0] WIDTH_C  = X_W'(WIDTH);
  localparam logic [Y_W-1:0] HEIGHT_C = Y_W'(HEIGHT);

  state_t         state_q, state_nxt;
  box_t           raw, filt_q, ema;
  logic [X_W-1:0] ema_left, ema_right;
  logic [Y_W-1:0] ema_top, ema_bot;
  logic [3:0]     near;
  logic [HW-1:0]  hit_q, hit_inc;
  logic [MW-1:0]  miss_q, miss_inc;
  logic           acc_q, vld_q;
  logic           sane, cons, acq_phase, accept, load_raw, load_ema, miss_frame;

  assign raw = {left_in, right_in, top_in, bot_in};
  assign ema = {ema_left, ema_right, ema_top, ema_bot};

  edge_ema #(.W(X_W), .SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX)) u_left (
    .filt(filt_q.left),  .raw(raw.left),  .nxt(ema_left),  .near(near[0]));
  edge_ema #(.W(X_W), .SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX)) u_right (
    .filt(filt_q.right), .raw(raw.right), .nxt(ema_right), .near(near[1]));
  edge_ema #(.W(Y_W), .SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX)) u_top (
    .filt(filt_q.top),   .raw(raw.top),   .nxt(ema_top),   .near(near[2]));
  edge_ema #(.W(Y_W), .SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX)) u_bot (
    .filt(filt_q.bot),   .raw(raw.bot),   .nxt(ema_bot),   .near(near[3]));

  assign sane = valid_in && (raw.left <= raw.right) && (raw.top <= raw.bot)
             && (raw.right < WIDTH_C) && (raw.bot < HEIGHT_C);
  assign cons = sane && (&near);

  // While unlocked any sane box is taken (re-seeding if it jumped); once locked only consistent ones.
  assign acq_phase  = (state_q == SEARCH) || (state_q == ACQUIRE);
  assign accept     = acq_phase ? sane : cons;
  assign load_raw   = sane && ((state_q == SEARCH) || ((state_q == ACQUIRE) && !cons));
  assign load_ema   = accept && !load_raw;
  assign miss_frame = frame_in && !acc_q && !accept;
  assign hit_inc    = hit_q + HW'(1);
  assign miss_inc   = miss_q + MW'(1);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      SEARCH:  if (accept) state_nxt = ACQUIRE;
      ACQUIRE: begin
        if (load_ema && hit_inc == LOCK_C) state_nxt = TRACK;
        else if (miss_frame)               state_nxt = SEARCH;
      end
      TRACK:   if (miss_frame) state_nxt = COAST;
      COAST: begin
        if (accept)                                state_nxt = TRACK;
        else if (miss_frame && miss_inc == LOST_C) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    valid_out  = vld_q;
    left_out   = filt_q.left;
    right_out  = filt_q.right;
    top_out    = filt_q.top;
    bot_out    = filt_q.bot;
    locked_out = (state_q == TRACK) || (state_q == COAST);
    state_out  = state_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      filt_q <= '0;
      hit_q  <= '0;
      miss_q <= '0;
      acc_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= accept;
      if (load_raw)      filt_q <= raw;
      else if (load_ema) filt_q <= ema;

      if (load_raw)                                hit_q <= HW'(1);
      else if (load_ema && state_q == ACQUIRE)     hit_q <= hit_inc;
      else if (state_nxt == SEARCH)                hit_q <= '0;

      if (accept || state_nxt == SEARCH) miss_q <= '0;
      else if (miss_frame)               miss_q <= (state_q == TRACK) ? MW'(1) : miss_inc;

      // A sample coincident with frame_in is credited to the closing frame above, then the flag clears.
      if (frame_in)    acc_q <= 1'b0;
      else if (accept) acc_q <= 1'b1;
    end
  end

endmodule

// File: doc/bbox_filter.md
BBOX_FILTER -- requirements
Module: bbox_filter

Interface
REQ-001 Parameter WIDTH, 480, horizontal mask extent in pixels; x coordinates SHALL be < WIDTH.
REQ-002 Parameter HEIGHT, 640, vertical mask extent in pixels; y coordinates SHALL be < HEIGHT.
REQ-003 Parameter SHIFT, 2, EMA weight exponent; alpha = 2^-SHIFT.
REQ-004 Parameter JUMP_MAX, 64, maximum per-edge deviation in pixels accepted as consistent.
REQ-005 Parameter LOCK_FRAMES, 3, consistent samples required to lock.
REQ-006 Parameter LOST_FRAMES, 8, consecutive missed frames before the lock is dropped.
REQ-007 clk_in  in  1  system clock (65 MHz pixel clock); the block SHALL have this one clock only.
REQ-008 rst_in  in  1  reset, synchronous and active-low.
REQ-009 valid_in  in  1  one-cycle pulse qualifying a raw box from the edge finder.
REQ-010 left_in, right_in  in  11 each  raw x edges.
REQ-011 top_in, bot_in  in  10 each  raw y edges.
REQ-012 frame_in  in  1  one-cycle pulse per video frame (hcount==0 && vcount==0).
REQ-013 valid_out  out  1  one-cycle pulse when the filtered box updates.
REQ-014 left_out, right_out  out  11 each; top_out, bot_out  out  10 each  filtered box.
REQ-015 locked_out  out  1  high in TRACK and COAST.
REQ-016 state_out  out  2  current FSM state encoding.

Function
REQ-017 A sample SHALL be sane iff left<=right, top<=bot, right<WIDTH and bot<HEIGHT; an insane sample SHALL be ignored with no state change.
REQ-018 A sane sample SHALL be consistent iff |raw-filt|<=JUMP_MAX on all four edges.
REQ-019 Outputs SHALL update, and valid_out SHALL pulse, exactly 1 cycle after an accepted valid_in; valid_in on consecutive cycles SHALL each see the prior update.
REQ-020 EMA step per edge: filt <= filt + ((raw-filt) >>> SHIFT), signed, 1-bit-extended width; if 0<|raw-filt|<2^SHIFT, step SHALL be +/-1 so filt converges exactly to raw.
REQ-021 Filtered values SHALL never leave the interval [min(filt,raw), max(filt,raw)]; no wrap-around.
REQ-022 SEARCH: sane sample -> filt=raw, hit_cnt=1, go ACQUIRE, valid_out pulses.
REQ-023 ACQUIRE: consistent sample -> EMA, hit_cnt+1; on reaching LOCK_FRAMES go TRACK. Sane inconsistent -> filt=raw, hit_cnt=1. frame_in with no accept in that frame -> SEARCH.
REQ-024 TRACK: consistent sample -> EMA, miss_cnt=0; inconsistent ignored. frame_in with no accept in frame -> COAST, miss_cnt=1.
REQ-025 COAST: filt held; consistent sample -> EMA, TRACK, miss_cnt=0. frame_in with no accept -> miss_cnt+1; at LOST_FRAMES -> SEARCH, locked_out low next cycle.
REQ-026 valid_in and frame_in in the same cycle: the sample SHALL be evaluated first and count toward the frame that frame_in closes.
REQ-027 Per-frame accept flag SHALL clear on every frame_in (after REQ-026 evaluation).

Reset
REQ-028 rst_in low at any clock edge, including mid-update, SHALL force SEARCH, all box outputs 0, valid_out 0, locked_out 0, hit_cnt/miss_cnt/accept flag 0; a coincident valid_in SHALL be dropped.

Configuration
REQ-029 Macro BBOX_FILTER_EMA_EN defined: EMA per REQ-020. Undefined: every accepted consistent sample SHALL load filt=raw directly; FSM, gating and latency unchanged.

Structure
REQ-030 Package bbox_pkg SHALL hold the state enum typedef (SEARCH=0, ACQUIRE=1, TRACK=2, COAST=3) and a packed box struct (left, right, top, bot).
REQ-031 One sub-module edge_ema (parameterised width and SHIFT) SHALL implement REQ-020/021 and be instantiated four times.

Verification
REQ-032 Reset, then samples (100,200,50,150) at three frames -> ACQUIRE, then TRACK after 3rd; locked_out=1, box=(100,200,50,150).
REQ-033 TRACK at left=100, sample left=103 (SHIFT=2) -> left_out 101, then 102, then 103 on repeats (+/-1 rule).
REQ-034 TRACK, sample left=300 (jump 200) -> ignored, box unchanged, no valid_out; insane sample left=250,right=200 -> ignored.
REQ-035 TRACK, 8 frame_in pulses with no valid_in -> COAST after 1st, SEARCH after 8th, locked_out=0; consistent sample after 5 misses -> TRACK, miss_cnt=0.
REQ-036 valid_in and frame_in same cycle in COAST -> sample accepted, state TRACK, no miss counted.
REQ-037 rst_in low during valid_in in TRACK -> next cycle SEARCH, all outputs 0, no valid_out.
